// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - word-to-bit sequencer around a programmable 4-bit Mealy pattern detector
module seq_scan_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              found,
    output logic [CNT_W-1:0]  first_pos,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [3:0]        pattern;
    logic              overlap;
    logic [DATA_W-1:0] word;
    logic              last;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        hist;
    logic [1:0]        hlen;
    logic [CNT_W-1:0]  pos;
    logic              x;
    logic              hit;

    // Current serial bit and the Mealy match decision for it
    always_comb begin
        x   = word[idx];
        hit = (hlen == 2'd3) && ({hist, x} == pattern);
    end

    // Frame sequencer, detector history and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pattern     <= '0;
            overlap     <= 1'b0;
            word        <= '0;
            last        <= 1'b0;
            idx         <= '0;
            hist        <= '0;
            hlen        <= '0;
            pos         <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            found       <= 1'b0;
            first_pos   <= '0;
            done        <= 1'b0;
        end else begin
            match <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pattern     <= cfg_pattern;
                        overlap     <= cfg_overlap;
                        match_count <= '0;
                        found       <= 1'b0;
                        first_pos   <= '0;
                        pos         <= '0;
                        hist        <= '0;
                        hlen        <= '0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        word     <= in_data;
                        last     <= in_last;
                        idx      <= IDX_W'(DATA_W - 1);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    match <= hit;
                    if (hit) begin
                        if (match_count != '1) begin
                            match_count <= match_count + CNT_W'(1);
                        end
                        if (!found) begin
                            found     <= 1'b1;
                            first_pos <= pos;
                        end
                    end
                    // Non-overlap drops the history so the next match needs four fresh bits
                    if (hit && !overlap) begin
                        hlen <= 2'd0;
                    end else begin
                        hist <= {hist[1:0], x};
                        if (hlen != 2'd3) begin
                            hlen <= hlen + 2'd1;
                        end
                    end
                    if (pos != '1) begin
                        pos <= pos + CNT_W'(1);
                    end
                    if (idx == '0) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= LOAD;
                        end
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - directed self-checking bench for seq_scan_ctrl
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_pattern;
    logic        cfg_overlap;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;

    logic        in_ready, busy, match, found, done;
    logic [15:0] match_count, first_pos;

    logic        r4, b4, m4, f4, d4;
    logic [3:0]  mc4, fp4;

    int n_vec = 0;
    int n_bad = 0;
    int n_match = 0;
    int cyc_cnt = 0;
    int t0, m0, w;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .busy(busy), .match(match),
        .match_count(match_count), .found(found), .first_pos(first_pos), .done(done)
    );

    seq_scan_ctrl #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(r4), .busy(b4), .match(m4),
        .match_count(mc4), .found(f4), .first_pos(fp4), .done(d4)
    );

    // Cycle and match-pulse counters, sampled on the active edge
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (match) n_match <= n_match + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [3:0] pat, input logic ovl);
        @(negedge clk);
        t0 = cyc_cnt;
        m0 = n_match;
        start = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_pattern = 4'h0;
        cfg_overlap = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", match_count, 0);
        check("rst_found", found, 0);
        check("rst_first", first_pos, 0);
        check("rst_done", done, 0);

        // Overlap, single word 0xB6
        start_frame(4'hB, 1'b1);
        check("ovl_ready_lat", in_ready, 1);
        send_word(8'hB6, 1'b1);
        wait_done();
        check("ovl_done_lat", cyc_cnt - t0, 10);
        check("ovl_count", match_count, 2);
        check("ovl_found", found, 1);
        check("ovl_first", first_pos, 3);
        // Backpressure: hold a valid word through DONE and IDLE
        in_valid = 1'b1;
        in_data  = 8'hB6;
        in_last  = 1'b1;
        @(negedge clk);
        check("ovl_pulses", n_match - m0, 2);
        check("bp_done_clr", done, 0);
        repeat (3) @(negedge clk);
        check("bp_idle_ready", in_ready, 0);
        check("bp_idle_busy", busy, 0);
        check("bp_hold_count", match_count, 2);
        start_frame(4'hB, 1'b1);
        check("bp_load_ready", in_ready, 1);
        @(negedge clk);
        check("bp_shift_ready", in_ready, 0);
        check("bp_busy", busy, 1);
        start = 1'b1;
        cfg_pattern = 4'hF;
        cfg_overlap = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("bp_count", match_count, 2);
        check("bp_first", first_pos, 3);
        repeat (4) @(negedge clk);
        check("bp_no_restart", busy, 0);
        check("bp_after_ready", in_ready, 0);
        in_valid = 1'b0;

        // Non-overlap, same stimulus
        start_frame(4'hB, 1'b0);
        send_word(8'hB6, 1'b1);
        wait_done();
        check("novl_count", match_count, 1);
        check("novl_first", first_pos, 3);
        repeat (2) @(negedge clk);
        check("novl_pulses", n_match - m0, 1);

        // Match spanning a word boundary
        start_frame(4'hB, 1'b1);
        send_word(8'h01, 1'b0);
        send_word(8'h60, 1'b1);
        wait_done();
        check("xw_count", match_count, 1);
        check("xw_first", first_pos, 10);

        // Saturation on the narrow-counter instance
        start_frame(4'hF, 1'b1);
        send_word(8'hFF, 1'b0);
        wait_ready();
        check("sat_w1", mc4, 5);
        send_word(8'hFF, 1'b0);
        wait_ready();
        check("sat_w2", mc4, 13);
        send_word(8'hFF, 1'b1);
        wait_done();
        check("sat_w3", mc4, 15);
        check("sat_first", fp4, 3);
        check("sat_found", f4, 1);
        check("wide_count", match_count, 21);

        // Reset during the second word of a frame
        start_frame(4'hB, 1'b1);
        send_word(8'hB6, 1'b0);
        send_word(8'hB6, 1'b1);
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_count", match_count, 2);
        rst = 1'b1;
        #1;
        check("ab_busy", busy, 0);
        check("ab_count", match_count, 0);
        check("ab_found", found, 0);
        check("ab_first", first_pos, 0);
        check("ab_match", match, 0);
        check("ab_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        m0 = n_match;
        repeat (12) @(negedge clk);
        check("ab_no_done", done, 0);
        check("ab_idle", busy, 0);
        check("ab_no_pulse", n_match - m0, 0);
        start_frame(4'hB, 1'b1);
        send_word(8'hB6, 1'b1);
        wait_done();
        check("post_count", match_count, 2);
        check("post_first", first_pos, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-level controller that sequences a programmable 4-bit Mealy sequence detector over a stream of parallel data words. It accepts words over a valid/ready handshake, serialises each word MSB-first into the detector at one bit per cycle, and counts matches. It records the bit position of the first match and signals frame completion. It sits between a word-wide source (register file or FIFO) and the bit-serial detection datapath. The detector supports overlap and non-overlap modes.

## Interface
- DATA_W, 8: input word width in bits, minimum 2.
- CNT_W, 16: width of the match counter and the position counter.

- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle frame start; sampled only in IDLE.
- cfg_pattern  in  4  pattern to detect; bit 3 is the first bit received.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  input word, shifted MSB first.
- in_last  in  1  word is the final word of the frame; qualified by in_valid.
- in_ready  out  1  controller can accept a word.
- busy  out  1  a frame is in progress (state is not IDLE).
- match  out  1  one-cycle pulse in the cycle the matching bit is shifted.
- match_count  out  CNT_W  number of matches in the current or last frame; saturating.
- found  out  1  at least one match has occurred in the current or last frame.
- first_pos  out  CNT_W  frame bit index (0-based) of the final bit of the first match.
- done  out  1  one-cycle pulse at frame end.

## Operation
- On reset, every output and all internal state is 0, and the FSM enters IDLE.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready = 0.
  - On start = 1: latch cfg_pattern and cfg_overlap.
  - Clear match_count, found, first_pos, the bit-position counter and the history; go to LOAD.
  - match_count, found and first_pos hold their previous values until start arrives.
- LOAD:
  - in_ready = 1.
  - When in_valid = 1: capture in_data and in_last, set the bit index to DATA_W-1, and go to SHIFT.
- SHIFT:
  - Each cycle, present bit x = word[index] to the detector.
  - Increment the position counter; it saturates at 2^CNT_W-1.
  - After bit 0: go to DONE if the captured last flag is 1, otherwise go to LOAD.
- DONE: assert done for one cycle, then go to IDLE.
- Detector state:
  - 3-bit history h holds the most recent bits.
  - hlen counts bits in the history, 0..3, saturating.
- Match rule: match = (hlen == 3) && ({h, x} == pattern).
- Overlap mode: after any bit, shift x into h and increment hlen.
- Non-overlap mode on a match: set hlen to 0 and do not shift x into h.
- History and hlen persist across words within a frame, so matches can span a word boundary.
- History and hlen clear only on start or reset.
- On each match:
  - match_count increments, saturating at 2^CNT_W-1.
  - If found = 0, set found = 1 and set first_pos to the current position.
- start is ignored while busy = 1.
- cfg_* inputs are sampled only at start; changing them mid-frame has no effect.
- rst asserted mid-frame aborts immediately: all outputs return to 0 and no done pulse is produced.

## Timing
- in_ready is a registered state decode and does not depend on in_valid.
- A word transfers on a cycle with in_valid && in_ready.
- in_valid may be held high while in_ready = 0. No word is consumed and no state changes.
- Per-word cost: 1 LOAD cycle plus DATA_W SHIFT cycles. Minimum throughput is DATA_W+1 cycles per word.
- The match pulse is registered. It is high in the cycle after the matching bit's SHIFT cycle.
- match_count and first_pos update on that same edge.
- done is asserted in the cycle after the final SHIFT cycle.
- match_count, found and first_pos are final and stable when done = 1.
- Latency from start to first in_ready = 1 is one cycle.

## Test plan
- Overlap: pattern 1011, overlap = 1, one word 0xB6 with in_last = 1 -> match pulses for bit positions 3 and 6; count = 2, found = 1, first_pos = 3, done 10 cycles after start.
- Non-overlap: same stimulus with overlap = 0 -> count = 1, first_pos = 3; bits 4..7 (0110) produce no match.
- Cross-word match: pattern 1011, words 0x01 then 0x60 (last) -> count = 1, first_pos = 10.
- Backpressure: in_valid held high with 0xB6 while the FSM is in DONE or IDLE -> no capture until LOAD; after start, exactly one word is consumed per handshake; repeated start while busy is ignored.
- Saturation: CNT_W = 4, pattern 1111, overlap = 1, three 0xFF words -> counts 5, then 13, then 15 (saturated); first_pos = 3.
- Reset mid-frame: rst asserted during SHIFT of the second word -> all outputs 0 and IDLE next cycle; a subsequent frame of 0xB6 gives count = 2.
